// File: rtl/ddr_row_pkg.sv
// Shared types and helpers for the DDR row scheduler: row geometry, FSM states
// and the word-address layout used by both request channels.
package ddr_row_pkg;

    localparam int WORDS    = 40;
    localparam int WORD_W   = 16;
    localparam int ROW_BITS = 640;
    localparam int ROW_W    = 9;
    localparam int CNT_W    = 6;
    localparam int ADDR_W   = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [ADDR_W-1:0] ddr_addr(input logic [ROW_W-1:0] row,
                                                   input logic [CNT_W-1:0] word);
        return {9'h000, row, word};
    endfunction

endpackage

// File: rtl/ddr_refresh_timer.sv
// Idle refresh timer plus OR-merge of every refresh source into one registered
// pulse, so coincident requests never produce back-to-back pulses.
module ddr_refresh_timer #(
    parameter int INTERVAL = 1040
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_idle,
    input  logic i_job_req,
    input  logic i_mid_req,
    input  logic i_end_req,
    output logic o_refresh
);

    localparam int TW = $clog2(INTERVAL + 1);

    logic [TW-1:0] r_timer;
    logic          r_refresh;
    logic          w_idle_req;
    logic          w_any_req;

    assign w_idle_req = i_idle && (r_timer == TW'(INTERVAL - 1));
    assign w_any_req  = i_job_req || i_mid_req || i_end_req || w_idle_req;

    // Any refresh restarts the idle interval; the timer rests at 0 during jobs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_timer   <= '0;
            r_refresh <= 1'b0;
        end else begin
            r_refresh <= w_any_req;
            if (w_any_req || !i_idle)
                r_timer <= '0;
            else
                r_timer <= r_timer + 1'b1;
        end
    end

    assign o_refresh = r_refresh;

endmodule

// File: rtl/ddr_row_scheduler.sv
// Job-based sequencer for one row write-back plus one row fetch over the
// 16-bit DDR word interface, with mid/end-of-burst and idle refresh.
module ddr_row_scheduler #(
    parameter int WORDS            = ddr_row_pkg::WORDS,
    parameter int MID_REFRESH_WORD = 19,
    parameter int REFRESH_INTERVAL = 1040
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_job_start,
    input  logic                          i_job_write,
    input  logic [8:0]                    i_write_row_num,
    input  logic [8:0]                    i_read_row_num,
    input  logic [ddr_row_pkg::ROW_BITS-1:0] i_write_row,
    output logic [ddr_row_pkg::ROW_BITS-1:0] o_read_row,
    output logic                          o_busy,
    output logic                          o_job_done,
    output logic                          o_job_dropped,
    output logic                          o_ddr_write,
    input  logic                          i_ddr_write_ack,
    output logic [23:0]                   o_ddr_write_addr,
    output logic [15:0]                   o_ddr_write_data,
    output logic                          o_ddr_read,
    input  logic                          i_ddr_read_ack,
    output logic [23:0]                   o_ddr_read_addr,
    input  logic [15:0]                   i_ddr_read_data,
    output logic                          o_ddr_refresh
);

    import ddr_row_pkg::*;

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [ROW_W-1:0]   r_wr_row, r_rd_row, w_wr_row_nxt, w_rd_row_nxt;

    logic               r_busy, r_job_done, r_job_dropped, r_ddr_write, r_ddr_read;
    logic [ADDR_W-1:0]  r_wr_addr, r_rd_addr;
    logic [WORD_W-1:0]  r_wr_data;
    logic [ROW_BITS-1:0] r_read_row;

    logic w_busy_nxt, w_done_nxt, w_dropped_nxt, w_write_nxt, w_read_nxt;
    logic w_job_acc, w_wr_acc, w_rd_acc, w_last, w_mid_req, w_end_req;

    // Acks only count in their own state; the other channel's ack is dropped.
    assign w_job_acc = (r_state == ST_IDLE) && i_job_start;
    assign w_wr_acc  = (r_state == ST_WRITE) && i_ddr_write_ack;
    assign w_rd_acc  = (r_state == ST_READ) && i_ddr_read_ack;
    assign w_last    = (r_cnt == CNT_W'(WORDS - 1));
    assign w_mid_req = (w_wr_acc || w_rd_acc) && (r_cnt == CNT_W'(MID_REFRESH_WORD));
    assign w_end_req = (w_wr_acc || w_rd_acc) && w_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_wr_row <= '0;
            r_rd_row <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wr_row <= w_wr_row_nxt;
            r_rd_row <= w_rd_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_wr_row_nxt = r_wr_row;
        w_rd_row_nxt = r_rd_row;
        case (r_state)
            ST_IDLE: begin
                if (i_job_start) begin
                    w_state_nxt  = i_job_write ? ST_WRITE : ST_READ;
                    w_cnt_nxt    = '0;
                    w_wr_row_nxt = i_write_row_num;
                    w_rd_row_nxt = i_read_row_num;
                end
            end
            ST_WRITE: begin
                if (w_wr_acc) begin
                    w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
                    if (w_last)
                        w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (w_rd_acc) begin
                    w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
                    if (w_last)
                        w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
        w_write_nxt   = (w_state_nxt == ST_WRITE);
        w_read_nxt    = (w_state_nxt == ST_READ);
        w_done_nxt    = (w_state_nxt == ST_DONE);
        w_dropped_nxt = i_job_start && (r_state != ST_IDLE);
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy        <= 1'b0;
            r_job_done    <= 1'b0;
            r_job_dropped <= 1'b0;
            r_ddr_write   <= 1'b0;
            r_ddr_read    <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_rd_addr     <= '0;
            r_read_row    <= '0;
        end else begin
            r_busy        <= w_busy_nxt;
            r_job_done    <= w_done_nxt;
            r_job_dropped <= w_dropped_nxt;
            r_ddr_write   <= w_write_nxt;
            r_ddr_read    <= w_read_nxt;
            if (w_write_nxt) begin
                r_wr_addr <= ddr_addr(w_wr_row_nxt, w_cnt_nxt);
                r_wr_data <= i_write_row[int'(w_cnt_nxt)*WORD_W +: WORD_W];
            end
            if (w_read_nxt)
                r_rd_addr <= ddr_addr(w_rd_row_nxt, w_cnt_nxt);
            if (w_rd_acc)
                r_read_row[int'(r_cnt)*WORD_W +: WORD_W] <= i_ddr_read_data;
        end
    end

    ddr_refresh_timer #(
        .INTERVAL (REFRESH_INTERVAL)
    ) u_refresh (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_idle    (r_state == ST_IDLE),
        .i_job_req (w_job_acc),
        .i_mid_req (w_mid_req),
        .i_end_req (w_end_req),
        .o_refresh (o_ddr_refresh)
    );

    assign o_read_row       = r_read_row;
    assign o_busy           = r_busy;
    assign o_job_done       = r_job_done;
    assign o_job_dropped    = r_job_dropped;
    assign o_ddr_write      = r_ddr_write;
    assign o_ddr_write_addr = r_wr_addr;
    assign o_ddr_write_data = r_wr_data;
    assign o_ddr_read       = r_ddr_read;
    assign o_ddr_read_addr  = r_rd_addr;

endmodule

// File: tb/tb_ddr_row_scheduler.sv
// Directed bench for ddr_row_scheduler: cycle-exact job timing, addresses,
// data, refresh placement, drop/abort behaviour and idle refresh.
module tb_ddr_row_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_start, job_write;
    logic [8:0]   wr_num, rd_num;
    logic [639:0] write_row;
    logic [639:0] read_row;
    logic         busy, job_done, job_dropped;
    logic         ddr_write, wack, ddr_read, rack, ddr_refresh;
    logic [23:0]  waddr, raddr;
    logic [15:0]  wdata, rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [639:0] exp_row;

    always #5 clk = ~clk;

    ddr_row_scheduler #(
        .WORDS(40), .MID_REFRESH_WORD(19), .REFRESH_INTERVAL(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_job_start(job_start), .i_job_write(job_write),
        .i_write_row_num(wr_num), .i_read_row_num(rd_num), .i_write_row(write_row),
        .o_read_row(read_row), .o_busy(busy), .o_job_done(job_done),
        .o_job_dropped(job_dropped), .o_ddr_write(ddr_write), .i_ddr_write_ack(wack),
        .o_ddr_write_addr(waddr), .o_ddr_write_data(wdata), .o_ddr_read(ddr_read),
        .i_ddr_read_ack(rack), .o_ddr_read_addr(raddr), .i_ddr_read_data(rdata),
        .o_ddr_refresh(ddr_refresh)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; job_start = 0; job_write = 0; wr_num = 0; rd_num = 0;
        wack = 0; rack = 0; rdata = 0;
        for (int k = 0; k < 40; k++) write_row[k*16 +: 16] = 16'(32'hA000 + k);
        tick; tick;
        n_tests++;
        if ({busy, job_done, job_dropped, ddr_write, ddr_read, ddr_refresh} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got %b exp 000000",
                     {busy, job_done, job_dropped, ddr_write, ddr_read, ddr_refresh});
        end
        n_tests++;
        if ({waddr, raddr, wdata} !== 64'h0 || read_row !== 640'h0) begin
            n_fail++;
            $display("FAIL reset_data waddr %h raddr %h wdata %h exp all 0", waddr, raddr, wdata);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_write_read;
        logic [4:0] exp_ctl;
        job_write = 1; wr_num = 9'd5; rd_num = 9'd7; job_start = 1;
        tick;
        job_start = 0;
        for (int k = 0; k < 40; k++) exp_row[k*16 +: 16] = 16'(32'h5000 + k);
        for (int c = 1; c <= 82; c++) begin
            exp_ctl = {1'(c <= 81), 1'(c == 81), 1'(c <= 40), 1'(c >= 41 && c <= 80),
                       1'(c == 1 || c == 21 || c == 41 || c == 61 || c == 81)};
            n_tests++;
            if ({busy, job_done, ddr_write, ddr_read, ddr_refresh} !== exp_ctl) begin
                n_fail++;
                $display("FAIL wr_job_ctl cycle %0d got %b exp %b", c,
                         {busy, job_done, ddr_write, ddr_read, ddr_refresh}, exp_ctl);
            end
            if (c <= 40) begin
                n_tests++;
                if (waddr !== 24'(32'h140 + c - 1) || wdata !== 16'(32'hA000 + c - 1)) begin
                    n_fail++;
                    $display("FAIL wr_addr_data cycle %0d got %h/%h exp %h/%h", c, waddr, wdata,
                             24'(32'h140 + c - 1), 16'(32'hA000 + c - 1));
                end
            end
            if (c >= 41 && c <= 80) begin
                n_tests++;
                if (raddr !== 24'(32'h1C0 + c - 41)) begin
                    n_fail++;
                    $display("FAIL rd_addr cycle %0d got %h exp %h", c, raddr, 24'(32'h1C0 + c - 41));
                end
            end
            if (c == 81) begin
                n_tests++;
                if (read_row !== exp_row) begin
                    n_fail++;
                    $display("FAIL wr_job_row got %h exp %h", read_row, exp_row);
                end
            end
            wack  = (c <= 40);
            rack  = (c >= 41 && c <= 80);
            rdata = 16'(32'h5000 + c - 41);
            tick;
        end
        wack = 0; rack = 0;
    endtask

    task automatic test_read_only_slow;
        int  k = 0;
        int  done_c = 0;
        logic saw_write = 0;
        job_write = 0; rd_num = 9'd3; job_start = 1;
        tick;
        job_start = 0;
        for (int j = 0; j < 40; j++) exp_row[j*16 +: 16] = 16'(32'h1000 + j);
        for (int c = 1; c <= 200; c++) begin
            if (ddr_write) saw_write = 1;
            if (job_done) begin
                done_c = c;
                break;
            end
            if (c % 3 == 0 && k < 40) begin
                n_tests++;
                if (raddr !== 24'(32'h0C0 + k)) begin
                    n_fail++;
                    $display("FAIL ro_addr word %0d got %h exp %h", k, raddr, 24'(32'h0C0 + k));
                end
                rack = 1; rdata = 16'(32'h1000 + k); k++;
            end else begin
                rack = 0;
            end
            tick;
        end
        rack = 0;
        n_tests++;
        if (done_c != 121) begin
            n_fail++;
            $display("FAIL ro_done_cycle got %0d exp 121", done_c);
        end
        n_tests++;
        if (read_row !== exp_row) begin
            n_fail++;
            $display("FAIL ro_row got %h exp %h", read_row, exp_row);
        end
        n_tests++;
        if (saw_write !== 1'b0) begin
            n_fail++;
            $display("FAIL ro_no_write got %b exp 0", saw_write);
        end
        tick;
    endtask

    task automatic test_dropped;
        logic [2:0] exp_ctl;
        job_write = 0; wr_num = 9'd0; rd_num = 9'd9; job_start = 1;
        tick;
        for (int j = 0; j < 40; j++) exp_row[j*16 +: 16] = 16'(32'h2000 + j);
        for (int c = 1; c <= 45; c++) begin
            exp_ctl = {1'(c == 11), 1'(c == 41), 1'b0};
            n_tests++;
            if ({job_dropped, job_done, ddr_write} !== exp_ctl) begin
                n_fail++;
                $display("FAIL drop_ctl cycle %0d got %b exp %b", c,
                         {job_dropped, job_done, ddr_write}, exp_ctl);
            end
            if (c <= 40) begin
                n_tests++;
                if (raddr !== 24'(32'h240 + c - 1)) begin
                    n_fail++;
                    $display("FAIL drop_addr cycle %0d got %h exp %h", c, raddr, 24'(32'h240 + c - 1));
                end
            end
            if (c == 41) begin
                n_tests++;
                if (read_row !== exp_row) begin
                    n_fail++;
                    $display("FAIL drop_row got %h exp %h", read_row, exp_row);
                end
            end
            job_start = (c == 10);
            if (c == 10) begin
                job_write = 1; wr_num = 9'd1; rd_num = 9'd2;
            end
            rack  = (c <= 40);
            rdata = 16'(32'h2000 + c - 1);
            tick;
        end
        rack = 0; job_start = 0;
    endtask

    task automatic test_dual_ack;
        job_write = 1; wr_num = 9'd4; rd_num = 9'd6; job_start = 1;
        tick;
        job_start = 0;
        wack = 1; rack = 1; rdata = 16'hDEAD;
        tick;
        wack = 0; rack = 0;
        n_tests++;
        if (waddr !== 24'h000101 || wdata !== 16'hA001 || ddr_read !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_ack_wr got %h/%h rd %b exp 000101/a001 rd 0", waddr, wdata, ddr_read);
        end
        n_tests++;
        if (read_row !== exp_row) begin
            n_fail++;
            $display("FAIL dual_ack_row got %h exp %h", read_row, exp_row);
        end
    endtask

    task automatic test_reset_mid_burst;
        int done_c = 0;
        int k = 0;
        for (int w = 1; w <= 12; w++) begin
            wack = 1;
            tick;
        end
        wack = 0;
        n_tests++;
        if (waddr !== 24'h00010D || ddr_write !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_abort_addr got %h wr %b exp 00010d wr 1", waddr, ddr_write);
        end
        rst = 1;
        tick;
        rst = 0;
        n_tests++;
        if ({busy, job_done, job_dropped, ddr_write, ddr_read, ddr_refresh} !== 6'b0 ||
            {waddr, raddr, wdata} !== 64'h0 || read_row !== 640'h0) begin
            n_fail++;
            $display("FAIL abort_outputs ctl %b waddr %h raddr %h wdata %h exp all 0",
                     {busy, job_done, job_dropped, ddr_write, ddr_read, ddr_refresh}, waddr, raddr, wdata);
        end
        for (int c = 0; c < 12; c++) begin
            tick;
            n_tests++;
            if ({busy, job_done} !== 2'b00) begin
                n_fail++;
                $display("FAIL abort_quiet cycle %0d got %b exp 00", c, {busy, job_done});
            end
        end
        job_write = 1; wr_num = 9'd5; rd_num = 9'd7; job_start = 1;
        tick;
        job_start = 0;
        n_tests++;
        if (waddr !== 24'h000140 || wdata !== 16'hA000 || ddr_write !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_word0 got %h/%h wr %b exp 000140/a000 wr 1", waddr, wdata, ddr_write);
        end
        for (int j = 0; j < 40; j++) exp_row[j*16 +: 16] = 16'(32'h3000 + j);
        for (int c = 1; c <= 100; c++) begin
            if (job_done) begin
                done_c = c;
                break;
            end
            wack  = ddr_write;
            rack  = ddr_read;
            rdata = 16'(32'h3000 + k);
            if (ddr_read) k++;
            tick;
        end
        wack = 0; rack = 0;
        n_tests++;
        if (done_c != 81 || read_row !== exp_row) begin
            n_fail++;
            $display("FAIL restart_job done cycle %0d exp 81, row %h exp %h", done_c, read_row, exp_row);
        end
        tick;
    endtask

    task automatic test_idle_refresh;
        logic found = 0;
        for (int i = 0; i < 20; i++) begin
            if (ddr_refresh) begin
                found = 1;
                break;
            end
            tick;
        end
        n_tests++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_refresh_seen got %b exp 1", found);
        end
        for (int i = 1; i <= 16; i++) begin
            tick;
            n_tests++;
            if (ddr_refresh !== 1'((i % 8) == 0)) begin
                n_fail++;
                $display("FAIL idle_period offset %0d got %b exp %b", i, ddr_refresh, 1'((i % 8) == 0));
            end
        end
        for (int i = 0; i < 7; i++) tick;
        job_write = 0; rd_num = 9'd1; job_start = 1;
        tick;
        job_start = 0;
        n_tests++;
        if ({ddr_refresh, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL coincide_pulse got %b exp 11", {ddr_refresh, busy});
        end
        tick;
        n_tests++;
        if (ddr_refresh !== 1'b0) begin
            n_fail++;
            $display("FAIL coincide_single got %b exp 0", ddr_refresh);
        end
        rst = 1;
        tick;
        rst = 0;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_write_read;
        test_read_only_slow;
        test_dropped;
        test_dual_ack;
        test_reset_mid_burst;
        test_idle_refresh;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
